// File: rtl/rf_write_arbiter_pkg.sv
// Shared constants and types for the register-file write arbiter.
// Defines the default sizes, requester indices and the round-robin pointer encoding.
package rf_write_arbiter_pkg;

    localparam int WORD_LEN_DEF  = 32;
    localparam int REG_COUNT_DEF = 16;

    // A single-register file still needs a 1-bit index.
    function automatic int addr_width(input int reg_count);
        return (reg_count > 1) ? $clog2(reg_count) : 1;
    endfunction

    localparam int ADDR_W_DEF = addr_width(REG_COUNT_DEF);

    localparam int REQ_WB  = 0;
    localparam int REQ_MEM = 1;

    typedef enum logic {
        PTR_WB  = 1'b0,
        PTR_MEM = 1'b1
    } ptr_e;

endpackage

// File: rtl/rf_write_arbiter_if.sv
// Valid/ready write channels of the two register-file writers.
// master = requester side, slave = arbiter side.
interface rf_write_arbiter_if
    import rf_write_arbiter_pkg::*;
#(
    parameter int WORD_LEN = WORD_LEN_DEF,
    parameter int ADDR_W   = ADDR_W_DEF
);

    logic                req0_valid;
    logic [ADDR_W-1:0]   req0_addr;
    logic [WORD_LEN-1:0] req0_data;
    logic                req0_ready;

    logic                req1_valid;
    logic [ADDR_W-1:0]   req1_addr;
    logic [WORD_LEN-1:0] req1_data;
    logic                req1_ready;

    modport master (
        output req0_valid, req0_addr, req0_data,
        input  req0_ready,
        output req1_valid, req1_addr, req1_data,
        input  req1_ready
    );

    modport slave (
        input  req0_valid, req0_addr, req0_data,
        output req0_ready,
        input  req1_valid, req1_addr, req1_data,
        output req1_ready
    );

endinterface

// File: rtl/rf_write_arbiter_rr.sv
// Two-input round-robin grant: combinational grant, registered priority pointer.
// The pointer always moves to the requester that was not served.
module rr_arbiter2
    import rf_write_arbiter_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] i_valid,
    input  logic       i_stall,
    output logic [1:0] o_grant
);

    ptr_e       r_ptr;
    ptr_e       w_ptr_next;
    logic [1:0] w_grant;

    always_comb begin
        w_grant    = 2'b00;
        w_ptr_next = r_ptr;
        if (!rst && !i_stall) begin
            case (i_valid)
                2'b01:   w_grant = 2'b01;
                2'b10:   w_grant = 2'b10;
                2'b11:   w_grant = (r_ptr == PTR_MEM) ? 2'b10 : 2'b01;
                default: w_grant = 2'b00;
            endcase
            if (w_grant[REQ_WB]) begin
                w_ptr_next = PTR_MEM;
            end else if (w_grant[REQ_MEM]) begin
                w_ptr_next = PTR_WB;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr <= PTR_WB;
        end else begin
            r_ptr <= w_ptr_next;
        end
    end

    assign o_grant = w_grant;

endmodule

// File: rtl/rf_write_arbiter.sv
// Arbitrates the writeback and memory-unit writers onto the single register-file
// write port, with a one-cycle output register and per-register pending flags.
module rf_write_arbiter
    import rf_write_arbiter_pkg::*;
#(
    parameter  int WORD_LEN  = WORD_LEN_DEF,
    parameter  int REG_COUNT = REG_COUNT_DEF,
    localparam int ADDR_W    = addr_width(REG_COUNT)
)(
    input  logic                 clk,
    input  logic                 rst,
    rf_write_arbiter_if.slave    req,
    input  logic                 rf_stall,
    output logic                 rf_we,
    output logic [ADDR_W-1:0]    rf_waddr,
    output logic [WORD_LEN-1:0]  rf_wdata,
    output logic [REG_COUNT-1:0] pending,
    output logic                 last_grant
);

    logic [1:0]          w_valid;
    logic [1:0]          w_grant;
    logic                w_xfer;
    logic                w_sel;
    logic                w_write;
    logic [ADDR_W-1:0]   w_addr;
    logic [WORD_LEN-1:0] w_data;

    logic                r_we;
    logic [ADDR_W-1:0]   r_waddr;
    logic [WORD_LEN-1:0] r_wdata;
    logic                r_last_grant;
    logic [REG_COUNT-1:0] r_pending;

    assign w_valid[REQ_WB]  = req.req0_valid;
    assign w_valid[REQ_MEM] = req.req1_valid;

    rr_arbiter2 u_arb (
        .clk     (clk),
        .rst     (rst),
        .i_valid (w_valid),
        .i_stall (rf_stall),
        .o_grant (w_grant)
    );

    assign req.req0_ready = w_grant[REQ_WB];
    assign req.req1_ready = w_grant[REQ_MEM];

    // A grant is only ever issued to a valid requester, so any grant is a transfer.
    assign w_xfer  = |w_grant;
    assign w_sel   = w_grant[REQ_MEM];
    assign w_addr  = w_sel ? req.req1_addr : req.req0_addr;
    assign w_data  = w_sel ? req.req1_data : req.req0_data;
    assign w_write = w_xfer && (w_addr != '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_we         <= 1'b0;
            r_waddr      <= '0;
            r_wdata      <= '0;
            r_last_grant <= 1'b0;
        end else begin
            r_we <= w_write;
            if (w_write) begin
                r_waddr <= w_addr;
                r_wdata <= w_data;
            end
            if (w_xfer) begin
                r_last_grant <= w_sel;
            end
        end
    end

    // A new acceptance to the same register outranks the clear of the one being presented.
    generate
        for (genvar gi = 0; gi < REG_COUNT; gi++) begin : g_pending
            logic w_set;
            logic w_clr;
            logic r_bit;

            assign w_set = w_write && (w_addr == ADDR_W'(gi));
            assign w_clr = r_we && (r_waddr == ADDR_W'(gi));

            always_ff @(posedge clk) begin
                if (rst) begin
                    r_bit <= 1'b0;
                end else if (w_set) begin
                    r_bit <= 1'b1;
                end else if (w_clr) begin
                    r_bit <= 1'b0;
                end
            end

            assign r_pending[gi] = r_bit;
        end
    endgenerate

    assign rf_we      = r_we;
    assign rf_waddr   = r_waddr;
    assign rf_wdata   = r_wdata;
    assign pending    = r_pending;
    assign last_grant = r_last_grant;

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Self-checking bench for rf_write_arbiter: directed vector table, hand-written
// corner sequences, then randomized traffic against an in-flight-count model.
module tb_rf_write_arbiter;

    localparam int WL = 32;
    localparam int RC = 16;
    localparam int AW = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          rf_stall = 1'b0;
    logic          rf_we;
    logic [AW-1:0] rf_waddr;
    logic [WL-1:0] rf_wdata;
    logic [RC-1:0] pending;
    logic          last_grant;

    int checks = 0;
    int errors = 0;

    rf_write_arbiter_if #(.WORD_LEN(WL), .ADDR_W(AW)) bus ();

    rf_write_arbiter #(.WORD_LEN(WL), .REG_COUNT(RC)) dut (
        .clk        (clk),
        .rst        (rst),
        .req        (bus),
        .rf_stall   (rf_stall),
        .rf_we      (rf_we),
        .rf_waddr   (rf_waddr),
        .rf_wdata   (rf_wdata),
        .pending    (pending),
        .last_grant (last_grant)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic          rst;
        logic          stall;
        logic          v0;
        logic [AW-1:0] a0;
        logic [WL-1:0] d0;
        logic          v1;
        logic [AW-1:0] a1;
        logic [WL-1:0] d1;
        logic          e_r0;
        logic          e_r1;
        logic          e_we;
        logic [AW-1:0] e_wa;
        logic [WL-1:0] e_wd;
        logic [RC-1:0] e_pend;
        logic          e_last;
    } vec_t;

    localparam int NVEC = 20;
    vec_t tbl [NVEC];

    function automatic vec_t mk(input logic r, input logic s,
                                input logic v0, input logic [AW-1:0] a0, input logic [WL-1:0] d0,
                                input logic v1, input logic [AW-1:0] a1, input logic [WL-1:0] d1,
                                input logic er0, input logic er1, input logic ewe,
                                input logic [AW-1:0] ewa, input logic [WL-1:0] ewd,
                                input logic [RC-1:0] ep, input logic el);
        vec_t v;
        v.rst = r;  v.stall = s;
        v.v0 = v0;  v.a0 = a0; v.d0 = d0;
        v.v1 = v1;  v.a1 = a1; v.d1 = d1;
        v.e_r0 = er0; v.e_r1 = er1; v.e_we = ewe;
        v.e_wa = ewa; v.e_wd = ewd; v.e_pend = ep; v.e_last = el;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic r, input logic s,
                         input logic v0, input logic [AW-1:0] a0, input logic [WL-1:0] d0,
                         input logic v1, input logic [AW-1:0] a1, input logic [WL-1:0] d1);
        rst = r;
        rf_stall = s;
        bus.req0_valid = v0; bus.req0_addr = a0; bus.req0_data = d0;
        bus.req1_valid = v1; bus.req1_addr = a1; bus.req1_data = d1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference model state: in-flight count per register (accepted, presentation not yet over)
    int            m_cnt [RC];
    int            m_ptr;
    logic          m_last;
    logic          m_we;
    logic [AW-1:0] m_waddr;
    logic [WL-1:0] m_wdata;

    function automatic int pick(input logic r, input logic s, input logic v0, input logic v1, input int ptr);
        if (r || s)        return -1;
        if (v0 && v1)      return ptr;
        if (v0)            return 0;
        if (v1)            return 1;
        return -1;
    endfunction

    task automatic model_reset();
        for (int a = 0; a < RC; a++) m_cnt[a] = 0;
        m_ptr = 0; m_last = 1'b0; m_we = 1'b0; m_waddr = '0; m_wdata = '0;
    endtask

    task automatic model_edge(input int g);
        logic [AW-1:0] ga;
        logic [WL-1:0] gd;
        if (rst) begin
            model_reset();
        end else begin
            if (m_we) m_cnt[m_waddr] = m_cnt[m_waddr] - 1;
            m_we = 1'b0;
            if (g >= 0) begin
                ga = (g == 1) ? bus.req1_addr : bus.req0_addr;
                gd = (g == 1) ? bus.req1_data : bus.req0_data;
                m_last = (g == 1);
                m_ptr  = 1 - g;
                if (ga != 0) begin
                    m_we = 1'b1; m_waddr = ga; m_wdata = gd;
                    m_cnt[ga] = m_cnt[ga] + 1;
                end
            end
        end
    endtask

    function automatic logic [RC-1:0] model_pending();
        logic [RC-1:0] p;
        for (int a = 0; a < RC; a++) p[a] = (m_cnt[a] > 0);
        return p;
    endfunction

    initial begin
        drive(1'b1, 1'b0, 1'b0, '0, '0, 1'b0, '0, '0);
        repeat (2) @(posedge clk);
        #1;

        // rst, stall, v0,a0,d0, v1,a1,d1 | r0,r1, we,wa,wd, pend, last
        tbl[0]  = mk(1,0, 1,4'd3,32'hA5,  0,4'd0,32'h0,   0,0, 0,4'd0,32'h0,   16'h0000,0);
        tbl[1]  = mk(0,0, 0,4'd0,32'h0,   0,4'd0,32'h0,   0,0, 0,4'd0,32'h0,   16'h0000,0);
        tbl[2]  = mk(0,0, 1,4'd3,32'hA5,  0,4'd0,32'h0,   1,0, 0,4'd0,32'h0,   16'h0000,0);
        tbl[3]  = mk(0,0, 0,4'd0,32'h0,   0,4'd0,32'h0,   0,0, 1,4'd3,32'hA5,  16'h0008,0);
        tbl[4]  = mk(0,0, 0,4'd0,32'h0,   0,4'd0,32'h0,   0,0, 0,4'd3,32'hA5,  16'h0000,0);
        tbl[5]  = mk(0,0, 0,4'd0,32'h0,   1,4'd2,32'h11,  0,1, 0,4'd3,32'hA5,  16'h0000,0);
        tbl[6]  = mk(0,0, 1,4'd1,32'h100, 1,4'd2,32'h200, 1,0, 1,4'd2,32'h11,  16'h0004,1);
        tbl[7]  = mk(0,0, 1,4'd1,32'h101, 1,4'd2,32'h200, 0,1, 1,4'd1,32'h100, 16'h0002,0);
        tbl[8]  = mk(0,0, 1,4'd1,32'h101, 1,4'd2,32'h201, 1,0, 1,4'd2,32'h200, 16'h0004,1);
        tbl[9]  = mk(0,0, 1,4'd1,32'h102, 1,4'd2,32'h201, 0,1, 1,4'd1,32'h101, 16'h0002,0);
        tbl[10] = mk(0,0, 1,4'd4,32'h44,  0,4'd0,32'h0,   1,0, 1,4'd2,32'h201, 16'h0004,1);
        tbl[11] = mk(0,0, 0,4'd0,32'h0,   1,4'd0,32'hFF,  0,1, 1,4'd4,32'h44,  16'h0010,0);
        tbl[12] = mk(0,0, 0,4'd0,32'h0,   0,4'd0,32'h0,   0,0, 0,4'd4,32'h44,  16'h0000,1);
        tbl[13] = mk(0,1, 1,4'd6,32'h66,  1,4'd7,32'h77,  0,0, 0,4'd4,32'h44,  16'h0000,1);
        tbl[14] = mk(0,1, 1,4'd6,32'h66,  1,4'd7,32'h77,  0,0, 0,4'd4,32'h44,  16'h0000,1);
        tbl[15] = mk(0,1, 1,4'd6,32'h66,  1,4'd7,32'h77,  0,0, 0,4'd4,32'h44,  16'h0000,1);
        tbl[16] = mk(0,0, 1,4'd6,32'h66,  1,4'd7,32'h77,  1,0, 0,4'd4,32'h44,  16'h0000,1);
        tbl[17] = mk(0,0, 0,4'd0,32'h0,   1,4'd7,32'h77,  0,1, 1,4'd6,32'h66,  16'h0040,0);
        tbl[18] = mk(0,0, 0,4'd0,32'h0,   0,4'd0,32'h0,   0,0, 1,4'd7,32'h77,  16'h0080,1);
        tbl[19] = mk(0,0, 0,4'd0,32'h0,   0,4'd0,32'h0,   0,0, 0,4'd7,32'h77,  16'h0000,1);

        for (int i = 0; i < NVEC; i++) begin
            drive(tbl[i].rst, tbl[i].stall, tbl[i].v0, tbl[i].a0, tbl[i].d0,
                  tbl[i].v1, tbl[i].a1, tbl[i].d1);
            #4;
            chk($sformatf("v%0d_ready0", i), 32'(bus.req0_ready), 32'(tbl[i].e_r0));
            chk($sformatf("v%0d_ready1", i), 32'(bus.req1_ready), 32'(tbl[i].e_r1));
            chk($sformatf("v%0d_we", i),     32'(rf_we),          32'(tbl[i].e_we));
            chk($sformatf("v%0d_waddr", i),  32'(rf_waddr),       32'(tbl[i].e_wa));
            chk($sformatf("v%0d_wdata", i),  rf_wdata,            tbl[i].e_wd);
            chk($sformatf("v%0d_pending", i), 32'(pending),       32'(tbl[i].e_pend));
            chk($sformatf("v%0d_last", i),   32'(last_grant),     32'(tbl[i].e_last));
            $display("vec %0d: r0=%0b r1=%0b we=%0b waddr=%0d wdata=0x%0h pend=0x%0h last=%0b",
                     i, bus.req0_ready, bus.req1_ready, rf_we, rf_waddr, rf_wdata, pending, last_grant);
            tick();
        end

        // Same register written by both requesters on consecutive cycles
        drive(0, 0, 1, 4'd5, 32'hA0, 0, 4'd0, 32'h0);
        #4; chk("same_a_r0", 32'(bus.req0_ready), 32'd1);
        $display("seq same-addr: req0 addr5 accepted=%0b", bus.req0_ready);
        tick();
        drive(0, 0, 0, 4'd0, 32'h0, 1, 4'd5, 32'hB1);
        #4; chk("same_b_r1", 32'(bus.req1_ready), 32'd1);
            chk("same_b_wdata", rf_wdata, 32'hA0);
            chk("same_b_pend", 32'(pending), 32'h0020);
        $display("seq same-addr: req1 addr5 accepted=%0b present=0x%0h", bus.req1_ready, rf_wdata);
        tick();
        drive(0, 0, 0, 4'd0, 32'h0, 0, 4'd0, 32'h0);
        #4; chk("same_c_we", 32'(rf_we), 32'd1);
            chk("same_c_wdata", rf_wdata, 32'hB1);
            chk("same_c_pend", 32'(pending), 32'h0020);
        $display("seq same-addr: present=0x%0h pend=0x%0h", rf_wdata, pending);
        tick();
        #4; chk("same_d_we", 32'(rf_we), 32'd0);
            chk("same_d_pend", 32'(pending), 32'h0000);
        $display("seq same-addr: drained pend=0x%0h", pending);
        tick();

        // Reset landing on the presentation cycle of an accepted write
        drive(0, 0, 1, 4'd9, 32'h99, 0, 4'd0, 32'h0);
        #4; chk("rst_a_r0", 32'(bus.req0_ready), 32'd1);
        tick();
        drive(1, 0, 1, 4'd9, 32'h98, 1, 4'd8, 32'h88);
        #4; chk("rst_b_r0", 32'(bus.req0_ready), 32'd0);
            chk("rst_b_r1", 32'(bus.req1_ready), 32'd0);
            chk("rst_b_pend", 32'(pending), 32'h0200);
        tick();
        drive(0, 0, 0, 4'd0, 32'h0, 0, 4'd0, 32'h0);
        #4; chk("rst_c_we", 32'(rf_we), 32'd0);
            chk("rst_c_waddr", 32'(rf_waddr), 32'd0);
            chk("rst_c_wdata", rf_wdata, 32'd0);
            chk("rst_c_pend", 32'(pending), 32'h0000);
            chk("rst_c_last", 32'(last_grant), 32'd0);
        $display("seq reset: we=%0b pend=0x%0h last=%0b", rf_we, pending, last_grant);
        tick();

        // Randomized traffic against the model
        begin
            logic          v [2];
            logic [AW-1:0] a [2];
            logic [WL-1:0] d [2];
            logic          r, s;
            int            g;
            for (int k = 0; k < 2; k++) begin v[k] = 1'b0; a[k] = '0; d[k] = '0; end
            drive(1, 0, 0, '0, '0, 0, '0, '0);
            tick();
            model_reset();
            for (int n = 0; n < 1500; n++) begin
                for (int k = 0; k < 2; k++) begin
                    if (!v[k] && ($urandom_range(0, 9) < 6)) begin
                        v[k] = 1'b1;
                        a[k] = AW'($urandom_range(0, 7));
                        d[k] = $urandom;
                    end
                end
                r = ($urandom_range(0, 49) == 0);
                s = ($urandom_range(0, 4) == 0);
                drive(r, s, v[0], a[0], d[0], v[1], a[1], d[1]);
                g = pick(r, s, v[0], v[1], m_ptr);
                #4;
                chk("rnd_ready0", 32'(bus.req0_ready), 32'(g == 0));
                chk("rnd_ready1", 32'(bus.req1_ready), 32'(g == 1));
                chk("rnd_we",     32'(rf_we),          32'(m_we));
                chk("rnd_waddr",  32'(rf_waddr),       32'(m_waddr));
                chk("rnd_wdata",  rf_wdata,            m_wdata);
                chk("rnd_pending", 32'(pending),       32'(model_pending()));
                chk("rnd_last",   32'(last_grant),     32'(m_last));
                if (n % 100 == 0)
                    $display("rnd %0d: rst=%0b stall=%0b grant=%0d we=%0b waddr=%0d pend=0x%0h",
                             n, r, s, g, rf_we, rf_waddr, pending);
                @(posedge clk);
                model_edge(g);
                #1;
                if (g >= 0) v[g] = 1'b0;
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/rf_write_arbiter.md
RF_WRITE_ARBITER -- requirements
Module: rf_write_arbiter

Interface
REQ-001 Parameter WORD_LEN, default 32, is the register data width in bits.
REQ-002 Parameter REG_COUNT, default 16, is the number of architectural registers; ADDR_W = ceil(log2(REG_COUNT)), which is 4 by default.
REQ-003 clk  input  1  system clock; all state updates on posedge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 req0_valid  input  1  requester 0 (pipeline writeback) holds a write.
REQ-006 req0_addr  input  ADDR_W  destination register of requester 0.
REQ-007 req0_data  input  WORD_LEN  write data of requester 0.
REQ-008 req0_ready  output  1  requester 0 write accepted this cycle.
REQ-009 req1_valid, req1_addr, req1_data, req1_ready  same widths and directions as requester 0; requester 1 is the multi-cycle memory unit.
REQ-010 rf_stall  input  1  when high, the register file write port is unavailable; no grants are issued.
REQ-011 rf_we  output  1  register file write enable (regWrite).
REQ-012 rf_waddr  output  ADDR_W  register file write index.
REQ-013 rf_wdata  output  WORD_LEN  register file write data.
REQ-014 pending  output  REG_COUNT  one bit per register; set while a write to that register has been accepted but not yet presented on rf_*.
REQ-015 last_grant  output  1  index of the most recently granted requester.

Function
REQ-016 Handshake: a transfer occurs in a cycle where reqN_valid & reqN_ready; once asserted, valid, addr and data are held stable by the requester until that transfer.
REQ-017 reqN_ready is combinational from the valid inputs, rf_stall and the priority pointer; at most one ready is high per cycle.
REQ-018 With rf_stall=0 and exactly one valid, that requester is granted in the same cycle.
REQ-019 With both valid and rf_stall=0, the requester selected by priority pointer ptr is granted; ptr then moves to the other requester (round-robin), so no requester waits more than one grant.
REQ-020 With a single valid, ptr is set to the requester not granted.
REQ-021 rf_stall=1 forces both readies to 0 and leaves ptr unchanged.
REQ-022 Latency: a transfer at posedge k drives rf_we=1, rf_waddr and rf_wdata from posedge k+1 for exactly one cycle; when there is no transfer, rf_we=0 on the following cycle.
REQ-023 A write to address 0 is accepted and updates ptr and last_grant, but produces rf_we=0 and never sets pending[0].
REQ-024 pending[a] is set on the transfer cycle and cleared on the cycle rf_we presents address a; set and clear for different addresses occur in the same cycle independently.
REQ-025 Back-to-back transfers to the same address are presented in grant order; pending stays set across the overlap and clears after the final presentation.
REQ-026 rf_waddr and rf_wdata hold their last values while rf_we=0.

Reset
REQ-027 On posedge clk with rst=1: rf_we=0, rf_waddr=0, rf_wdata=0, pending=0, ptr=0 (requester 0 first), last_grant=0.
REQ-028 While rst=1, both readies are 0; an accepted write that has not yet been presented when reset is asserted is discarded.

Structure
REQ-029 WORD_LEN and REG_COUNT defaults, the ADDR_W derivation and the requester index constants (REQ_WB=0, REQ_MEM=1) belong in the shared core package.
REQ-030 One sub-module, rr_arbiter2 (2-input round-robin grant with pointer), is natural; the output register and the pending tracking stay in rf_write_arbiter.

Verification
REQ-031 Reset, then req0 valid addr 3 data 0xA5 -> req0_ready the same cycle; next cycle rf_we=1, waddr=3, wdata=0xA5; pending[3] high for exactly 1 cycle.
REQ-032 Both valid for 4 transfers (req0 addr 1, req1 addr 2) -> grants alternate 0,1,0,1 and last_grant tracks the granted requester.
REQ-033 req1 addr 0 data 0xFF -> req1_ready=1, rf_we stays 0, pending stays 0.
REQ-034 rf_stall high 3 cycles with both valid -> no readies and ptr unchanged; after release, requester 0 is granted first.
REQ-035 req0 addr 5, then req1 addr 5 on consecutive cycles -> rf presents req0 data then req1 data; pending[5] clears only after the second presentation.
REQ-036 Assert rst one cycle after a transfer -> rf_we=0 on the next edge and pending=0.
